// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates among all producers, BURST serves only the owner.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Producer count of the reference configuration and its index width.
    // Instances with a different N_REQ size their indices with idx_width().
    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = $clog2(N_REQ_DEF);

    // Beat counter width; holds any burst length up to 15.
    localparam int CNT_W = 4;

    // Index width for n producers, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first asserted request after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Candidate k is producer (ptr + k + 1) mod N; candidate 0 has the highest priority.
    logic [W-1:0] cand_idx [N];
    logic [N-1:0] cand_vld;

    for (genvar k = 0; k < N; k++) begin : g_cand
        logic [W:0] sum;

        // One extra bit holds ptr + offset (at most 2N-1) before the explicit wrap,
        // which keeps non-power-of-two producer counts correct.
        assign sum           = {1'b0, ptr} + (W+1)'(k + 1);
        assign cand_idx[k]   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
        assign cand_vld[k]   = req[cand_idx[k]];
    end

    // Scan from the lowest priority upwards so the nearest candidate after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                found = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Latency: zero; a beat is written to the FIFO on the same edge it is accepted.
// Backpressure: fifo_full drops every req_ready; a stalled burst keeps its owner and count.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       fifo_WEN,
    output logic [DATA_W-1:0]          fifo_input_data,
    input  logic                       fifo_full,
    output logic                       busy,
    output logic [idx_width(N_REQ)-1:0] owner_id
);

    localparam int IDW = idx_width(N_REQ);

    // Count value of the final beat of a burst.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

    // After reset the pointer sits on the last producer so producer 0 is searched first.
    localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);

    arb_state_e       st,    st_nxt;
    logic [IDW-1:0]   owner, owner_nxt;
    logic [IDW-1:0]   ptr,   ptr_nxt;
    logic [CNT_W-1:0] cnt,   cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   sel;
    logic             owner_vld;
    logic             grant;

    // Producer data viewed as one word per producer.
    logic [N_REQ-1:0][DATA_W-1:0] req_words;
    assign req_words = req_data;

    rr_pick #(
        .N (N_REQ),
        .W (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Choose the producer served this cycle and whether a beat actually moves.
    always_comb begin
        sel       = (st == ST_BURST) ? owner : pick_idx;
        owner_vld = req_valid[owner];
        cnt_inc   = cnt + CNT_W'(1);
        if (reset || fifo_full) begin
            grant = 1'b0;
        end else if (st == ST_BURST) begin
            grant = owner_vld;
        end else begin
            grant = pick_found;
        end
    end

    // State register: FSM state, owner, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= ST_IDLE;
            owner <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
        end else begin
            st    <= st_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: grant in IDLE, count beats in BURST, release on limit or owner going idle.
    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        unique case (st)
            ST_IDLE: begin
                if (grant) begin
                    ptr_nxt   = pick_idx;
                    owner_nxt = pick_idx;
                    cnt_nxt   = CNT_W'(1);
                    st_nxt    = (MAX_BURST > 1) ? ST_BURST : ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!owner_vld) begin
                    // Owner went idle: give up the port; ptr already points at the owner.
                    st_nxt  = ST_IDLE;
                    cnt_nxt = '0;
                end else if (!fifo_full) begin
                    if (cnt_inc == BURST_LAST) begin
                        st_nxt  = ST_IDLE;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                // Owner valid but FIFO full: hold everything and keep ownership.
            end
            default: begin
                st_nxt  = ST_IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // Output logic: one-hot ready to the served producer, with matching FIFO write.
    always_comb begin
        req_ready       = '0;
        fifo_WEN        = 1'b0;
        fifo_input_data = '0;
        if (grant) begin
            req_ready[sel]  = 1'b1;
            fifo_WEN        = 1'b1;
            fifo_input_data = req_words[sel];
        end
    end

    assign busy     = (st == ST_BURST);
    assign owner_id = owner;

endmodule
